// File: rtl/dm_sized_ws.sv
// Byte-addressed data memory: byte/half/word access, load extension, WAIT_CYCLES
// wait states, req/ready/done handshake. Define DM_UNALIGNED_EN to perform misaligned accesses.
`timescale 1ns/1ps
module dm_sized_ws #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           din,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           dout,
  output logic                  err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LANES = 4;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  sx;
    logic [31:0]           din;
  } req_t;

  logic [7:0] mem [DEPTH];
  req_t   r;
  state_t state, nxt;
  logic [3:0] cnt;

  logic [LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [LANES-1:0][7:0]            rd_byte;
  logic [LANES-1:0]                 lane_en;
  logic                             misalign, reject;
  logic [31:0]                      load_data;

  // Each byte lane addresses its own byte; the modular add gives the wrap at the top
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_addr[i] = r.addr + ADDR_WIDTH'(i);
    assign rd_byte[i]   = mem[lane_addr[i]];
  end

  always_comb begin
    lane_en  = '0;
    misalign = 1'b0;
    case (r.size)
      2'b00: lane_en = 4'b0001;
      2'b01: begin lane_en = 4'b0011; misalign = r.addr[0]; end
      2'b10: begin lane_en = 4'b1111; misalign = |r.addr[1:0]; end
      default: lane_en = 4'b0000;
    endcase
`ifdef DM_UNALIGNED_EN
    reject = (r.size == 2'b11);
`else
    reject = (r.size == 2'b11) | misalign;
`endif
  end

  always_comb begin
    load_data = '0;
    case (r.size)
      2'b00:   load_data = {{24{r.sx & rd_byte[0][7]}}, rd_byte[0]};
      2'b01:   load_data = {{16{r.sx & rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
      2'b10:   load_data = rd_byte;
      default: load_data = '0;
    endcase
  end

  assign ready = (state == S_IDLE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (req) nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == CNT_LAST) nxt = S_ACCESS;
      S_ACCESS: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      dout  <= '0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      if (state == S_IDLE && req) cnt <= '0;
      if (state == S_WAIT)        cnt <= cnt + 4'd1;
      if (state == S_ACCESS) begin
        done <= 1'b1;
        err  <= reject;
        if (reject)     dout <= '0;
        else if (!r.we) dout <= load_data;
      end
    end
  end

  // Request capture needs no reset: it is only consumed after an accept
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req)
      r <= '{we: we, addr: addr, size: size, sx: sign_ext, din: din};
  end

  // Store commit is gated by rst_n so a reset during the access aborts it
  always_ff @(posedge clk) begin
    if (rst_n && state == S_ACCESS && r.we && !reject) begin
      for (int i = 0; i < LANES; i++)
        if (lane_en[i]) mem[lane_addr[i]] <= r.din[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dm_sized_ws.sv
// Directed bench for dm_sized_ws: expected results queued at issue, checked at done.
`timescale 1ns/1ps
module tb_dm_sized_ws;
  localparam int AW = 10;
  localparam int W  = 3;

  logic          clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [1:0]    size = '0;
  logic [31:0]   din = '0;
  logic          ready, done, err;
  logic [31:0]   dout;

  dm_sized_ws #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .din(din), .ready(ready), .done(done), .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dout;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  logic [31:0] cur_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one access, scramble inputs after accept, then check latency/err/dout at done
  task automatic acc(input string tag, input logic w, input logic [AW-1:0] a,
                     input logic [1:0] sz, input logic sx, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_dout);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin @(negedge clk); n++; end
    req = 1'b1; we = w; addr = a; size = sz; sign_ext = sx; din = d;
    e.err = e_err; e.dout = e_dout; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = '1; size = 2'b11; sign_ext = ~sx; din = 32'hDEAD_BEEF;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 32'(n), 32'(W + 1));
    chk({e.tag, "_err"}, {31'b0, err}, {31'b0, e.err});
    chk({e.tag, "_dout"}, dout, e.dout);
    cur_dout = e.dout;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_err",   {31'b0, err},   32'd0);
    chk("rst_dout",  dout,           32'd0);
    @(negedge clk); rst_n = 1'b1;

    // sizes and extension
    acc("sw10",  1, 10'h010, 2'b10, 0, 32'h8000_00F0, 0, cur_dout);
    acc("lb10",  0, 10'h010, 2'b00, 1, 32'h0,         0, 32'hFFFF_FFF0);
    acc("lbu10", 0, 10'h010, 2'b00, 0, 32'h0,         0, 32'h0000_00F0);
    acc("lh12",  0, 10'h012, 2'b01, 1, 32'h0,         0, 32'hFFFF_8000);
    acc("lhu12", 0, 10'h012, 2'b01, 0, 32'h0,         0, 32'h0000_8000);
    acc("lb13",  0, 10'h013, 2'b00, 1, 32'h0,         0, 32'hFFFF_FF80);
    acc("sb11",  1, 10'h011, 2'b00, 0, 32'hAAAA_AA7F, 0, cur_dout);
    acc("sh12",  1, 10'h012, 2'b01, 0, 32'h5555_1234, 0, cur_dout);
    acc("lw10",  0, 10'h010, 2'b10, 0, 32'h0,         0, 32'h1234_7FF0);

    // wait window: ready low, stray reqs ignored and not queued
    acc("sw40", 1, 10'h040, 2'b10, 0, 32'h0BAD_F00D, 0, cur_dout);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'h040; size = 2'b10; sign_ext = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      chk($sformatf("win_ready%0d", k), {31'b0, ready}, 32'd0);
      req = 1'b1; we = 1'b1; addr = 10'h040; size = 2'b10; din = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      req = 1'b0;
      chk($sformatf("win_done%0d", k), {31'b0, done}, (k == W + 1) ? 32'd1 : 32'd0);
    end
    chk("win_dout", dout, 32'h0BAD_F00D);
    chk("win_err", {31'b0, err}, 32'd0);
    cur_dout = 32'h0BAD_F00D;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("win_quiet%0d", k), {31'b0, done}, 32'd0);
    end
    acc("lw40", 0, 10'h040, 2'b10, 0, 32'h0, 0, 32'h0BAD_F00D);

    // errors
    acc("sw20",   1, 10'h020, 2'b10, 0, 32'h1234_5678, 0, cur_dout);
    acc("sh21",   1, 10'h021, 2'b01, 0, 32'h0000_BEEF, 1, 32'h0);
    acc("lw20",   0, 10'h020, 2'b10, 0, 32'h0,         0, 32'h1234_5678);
    acc("ld_sz3", 0, 10'h020, 2'b11, 0, 32'h0,         1, 32'h0);

    // top-of-memory word store at a misaligned address
    acc("sw3fc", 1, 10'h3FC, 2'b10, 0, 32'hA5A5_A5A5, 0, cur_dout);
    acc("sw000", 1, 10'h000, 2'b10, 0, 32'h0,         0, cur_dout);
`ifdef DM_UNALIGNED_EN
    acc("sw3fe", 1, 10'h3FE, 2'b10, 0, 32'h4433_2211, 0, cur_dout);
    acc("lw3fe", 0, 10'h3FE, 2'b10, 0, 32'h0,         0, 32'h4433_2211);
    acc("lw3fc", 0, 10'h3FC, 2'b10, 0, 32'h0,         0, 32'h2211_A5A5);
    acc("lw000", 0, 10'h000, 2'b10, 0, 32'h0,         0, 32'h0000_4433);
    acc("lb3ff", 0, 10'h3FF, 2'b00, 0, 32'h0,         0, 32'h0000_0022);
`else
    acc("sw3fe", 1, 10'h3FE, 2'b10, 0, 32'h4433_2211, 1, 32'h0);
    acc("lw3fc", 0, 10'h3FC, 2'b10, 0, 32'h0,         0, 32'hA5A5_A5A5);
    acc("lw000", 0, 10'h000, 2'b10, 0, 32'h0,         0, 32'h0);
    acc("lh3ff", 0, 10'h3FF, 2'b01, 0, 32'h0,         1, 32'h0);
`endif

    // reset during wait aborts a store
    acc("sw50", 1, 10'h050, 2'b10, 0, 32'h1111_1111, 0, cur_dout);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 10'h050; size = 2'b10; din = 32'h2222_2222;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("ab_ready", {31'b0, ready}, 32'd1);
    chk("ab_dout",  dout,           32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ab_quiet%0d", k), {31'b0, done}, 32'd0);
    end
    cur_dout = '0;
    acc("lw50", 0, 10'h050, 2'b10, 0, 32'h0, 0, 32'h1111_1111);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
